// File: rtl/mac_weight_loader_pkg.sv
// Shared types and lane geometry for the MAC weight loader.
// A 64-bit buffer word holds two slots of four byte lanes (a..d).
package mac_weight_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SET   = 2'd3
  } state_e;

  localparam int NUM_LANES   = 4;
  localparam int NUM_SLOTS   = 2;
  localparam int LANE_BITS   = 8;
  localparam int WORD_BITS   = NUM_LANES * NUM_SLOTS * LANE_BITS;

  localparam int LANE_A_OFS  = 0;
  localparam int LANE_B_OFS  = 8;
  localparam int LANE_C_OFS  = 16;
  localparam int LANE_D_OFS  = 24;
  localparam int SLOT_STRIDE = NUM_LANES * LANE_BITS;

  function automatic logic [LANE_BITS-1:0] lane_byte(input logic [WORD_BITS-1:0] word,
                                                     input int lane_ofs,
                                                     input int slot);
    return word[slot*SLOT_STRIDE + lane_ofs +: LANE_BITS];
  endfunction

endpackage

// File: rtl/mac_weight_loader.sv
// Streams one weight tile (ARRAY_ROWS buffer words) into the array load chain,
// then commits the shadow weights with a single set_weight pulse once the array is idle.
module mac_weight_loader
  import mac_weight_loader_pkg::*;
#(
  parameter int ARRAY_ROWS        = 8,
  parameter int BUFFER_ADDR_WIDTH = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [BUFFER_ADDR_WIDTH-1:0] base_addr_i,
  input  logic                         array_busy_i,
  output logic                         buf_rd_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_rd_addr_o,
  input  logic [63:0]                  buf_rd_data_i,
  output logic                         prepare_weight_o,
  output logic                         set_weight_o,
  output logic [7:0]                   o_load_weight_data_a_0,
  output logic [7:0]                   o_load_weight_data_b_0,
  output logic [7:0]                   o_load_weight_data_c_0,
  output logic [7:0]                   o_load_weight_data_d_0,
  output logic [7:0]                   o_load_weight_data_a_1,
  output logic [7:0]                   o_load_weight_data_b_1,
  output logic [7:0]                   o_load_weight_data_c_1,
  output logic [7:0]                   o_load_weight_data_d_1,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int              ROW_W    = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_ROWS - 1);

  state_e                       state_q, state_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [BUFFER_ADDR_WIDTH-1:0] base_q, base_d;
  logic                         prepare_q, prepare_d;
  logic [BUFFER_ADDR_WIDTH-1:0] addr_ofs;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    base_d       = base_q;
    buf_rd_en_o  = 1'b0;
    set_weight_o = 1'b0;
    done_o       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d  = base_addr_i;
          row_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        buf_rd_en_o = 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = ST_DRAIN;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_SET;
      end
      ST_SET: begin
        // Commit waits for the array; a reset in this cycle suppresses the pulse.
        if (!array_busy_i && rst_n) begin
          set_weight_o = 1'b1;
          done_o       = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    prepare_d = buf_rd_en_o;
  end

  // Offset arithmetic is done at address width so base+k wraps at the top of the buffer.
  assign addr_ofs      = BUFFER_ADDR_WIDTH'(row_q);
  assign buf_rd_addr_o = buf_rd_en_o ? (base_q + addr_ofs) : '0;
  assign busy_o        = (state_q != ST_IDLE);
  assign prepare_weight_o = prepare_q;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      base_q    <= '0;
      prepare_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      base_q    <= base_d;
      prepare_q <= prepare_d;
    end
  end

  // Read data arrives one cycle after the strobe, i.e. exactly while prepare is high.
  always_comb begin
    o_load_weight_data_a_0 = '0;
    o_load_weight_data_b_0 = '0;
    o_load_weight_data_c_0 = '0;
    o_load_weight_data_d_0 = '0;
    o_load_weight_data_a_1 = '0;
    o_load_weight_data_b_1 = '0;
    o_load_weight_data_c_1 = '0;
    o_load_weight_data_d_1 = '0;
    if (prepare_q) begin
      o_load_weight_data_a_0 = lane_byte(buf_rd_data_i, LANE_A_OFS, 0);
      o_load_weight_data_b_0 = lane_byte(buf_rd_data_i, LANE_B_OFS, 0);
      o_load_weight_data_c_0 = lane_byte(buf_rd_data_i, LANE_C_OFS, 0);
      o_load_weight_data_d_0 = lane_byte(buf_rd_data_i, LANE_D_OFS, 0);
      o_load_weight_data_a_1 = lane_byte(buf_rd_data_i, LANE_A_OFS, 1);
      o_load_weight_data_b_1 = lane_byte(buf_rd_data_i, LANE_B_OFS, 1);
      o_load_weight_data_c_1 = lane_byte(buf_rd_data_i, LANE_C_OFS, 1);
      o_load_weight_data_d_1 = lane_byte(buf_rd_data_i, LANE_D_OFS, 1);
    end
  end

endmodule

// File: tb/tb_mac_weight_loader.sv
// Directed bench for mac_weight_loader: three instances (8, 4 and 1 rows)
// share clock and reset, each with its own one-cycle-latency buffer model.
module tb_mac_weight_loader;

  localparam int NI = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NI-1:0]     start;
  logic [14:0]       base [NI];
  logic [NI-1:0]     abusy;
  logic [NI-1:0]     en, prep, setw, bsy, done;
  logic [14:0]       addr [NI];
  logic [7:0]        ld   [NI][8];
  logic [63:0]       mem  [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [63:0] rd_data;

    mac_weight_loader #(
      .ARRAY_ROWS       ((g == 0) ? 8 : ((g == 1) ? 4 : 1)),
      .BUFFER_ADDR_WIDTH(15)
    ) u_dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .start_i               (start[g]),
      .base_addr_i           (base[g]),
      .array_busy_i          (abusy[g]),
      .buf_rd_en_o           (en[g]),
      .buf_rd_addr_o         (addr[g]),
      .buf_rd_data_i         (rd_data),
      .prepare_weight_o      (prep[g]),
      .set_weight_o          (setw[g]),
      .o_load_weight_data_a_0(ld[g][0]),
      .o_load_weight_data_b_0(ld[g][1]),
      .o_load_weight_data_c_0(ld[g][2]),
      .o_load_weight_data_d_0(ld[g][3]),
      .o_load_weight_data_a_1(ld[g][4]),
      .o_load_weight_data_b_1(ld[g][5]),
      .o_load_weight_data_c_1(ld[g][6]),
      .o_load_weight_data_d_1(ld[g][7]),
      .busy_o                (bsy[g]),
      .done_o                (done[g])
    );

    always @(posedge clk) begin
      if (en[g] === 1'b1) rd_data <= mem[addr[g][3:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int g, input logic [14:0] b);
    start[g] = 1'b1;
    base[g]  = b;
    tick();
    start[g] = 1'b0;
  endtask

  // {en, addr, prep, set, done, busy}
  function automatic logic [19:0] obs(input int g);
    return {en[g], addr[g], prep[g], setw[g], done[g], bsy[g]};
  endfunction

  // Lanes reassembled in buffer-word order: d_1 ... a_0.
  function automatic logic [63:0] lanes(input int g);
    return {ld[g][7], ld[g][6], ld[g][5], ld[g][4], ld[g][3], ld[g][2], ld[g][1], ld[g][0]};
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) mem[i] = 64'h0101_0101_0101_0101 * 64'(((i % 8) + 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = '0;
    abusy = '0;
    for (int g = 0; g < NI; g++) base[g] = '0;
    fill_ramp();
    repeat (3) tick();
    for (int g = 0; g < NI; g++) begin
      n_cmp++;
      if (obs(g) !== 20'h0) begin
        n_bad++;
        $display("FAIL reset_outputs inst%0d: got %h want 00000", g, obs(g));
      end
      n_cmp++;
      if (lanes(g) !== 64'h0) begin
        n_bad++;
        $display("FAIL reset_lanes inst%0d: got %h want 0", g, lanes(g));
      end
    end
  endtask

  task automatic test_basic_load();
    logic [19:0] exp_obs;
    logic [7:0]  exp_b;
    logic        e_en, e_prep, e_set, e_busy;
    logic [14:0] e_addr;
    // Start is presented together with reset release: the first edge must take it.
    start[0] = 1'b1;
    base[0]  = 15'h0010;
    rst_n    = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      e_en    = (c <= 8);
      e_addr  = e_en ? 15'(16 + c - 1) : 15'h0;
      e_prep  = (c >= 2) && (c <= 9);
      e_set   = (c == 10);
      e_busy  = (c <= 10);
      exp_b   = e_prep ? 8'(c - 1) : 8'h00;
      exp_obs = {e_en, e_addr, e_prep, e_set, e_set, e_busy};
      n_cmp++;
      if (obs(0) !== exp_obs) begin
        n_bad++;
        $display("FAIL basic_ctrl cycle%0d: got %h want %h", c, obs(0), exp_obs);
      end
      n_cmp++;
      if (lanes(0) !== {8{exp_b}}) begin
        n_bad++;
        $display("FAIL basic_lanes cycle%0d: got %h want %h", c, lanes(0), {8{exp_b}});
      end
      tick();
    end
  endtask

  task automatic test_lane_map();
    for (int i = 0; i < 16; i++) mem[i] = 64'h0;
    mem[0] = 64'hA500_0000_0000_0000;
    mem[1] = 64'h0807_0605_0403_0201;
    kick(0, 15'h0010);
    tick();
    n_cmp++;
    if (lanes(0) !== 64'hA500_0000_0000_0000 || ld[0][7] !== 8'hA5) begin
      n_bad++;
      $display("FAIL lane_top_byte: got %h want a500000000000000", lanes(0));
    end
    tick();
    n_cmp++;
    if (ld[0][0] !== 8'h01 || ld[0][1] !== 8'h02 || ld[0][2] !== 8'h03 || ld[0][3] !== 8'h04 ||
        ld[0][4] !== 8'h05 || ld[0][5] !== 8'h06 || ld[0][6] !== 8'h07 || ld[0][7] !== 8'h08) begin
      n_bad++;
      $display("FAIL lane_order: got %h want 0807060504030201", lanes(0));
    end
    repeat (10) tick();
    n_cmp++;
    if (bsy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL lane_map_idle: busy got %b want 0", bsy[0]);
    end
    fill_ramp();
  endtask

  task automatic test_busy_hold();
    abusy[0] = 1'b1;
    kick(0, 15'h0010);
    for (int c = 1; c <= 16; c++) begin
      if (c >= 15) abusy[0] = 1'b0;
      #1;
      n_cmp++;
      if ({setw[0], done[0], bsy[0]} !== {(c == 15), (c == 15), (c <= 15)}) begin
        n_bad++;
        $display("FAIL busy_hold cycle%0d: set/done/busy got %b%b%b want %b%b%b", c,
                 setw[0], done[0], bsy[0], (c == 15), (c == 15), (c <= 15));
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int en_cnt = 0;
    int done_cnt = 0;
    int late_busy = 0;
    kick(0, 15'h0010);
    for (int c = 1; c <= 25; c++) begin
      start[0] = (c == 3) || (c == 10);
      #1;
      if (en[0] === 1'b1) en_cnt++;
      if (done[0] === 1'b1) done_cnt++;
      if (c >= 11 && bsy[0] !== 1'b0) late_busy++;
      tick();
    end
    start[0] = 1'b0;
    n_cmp++;
    if (en_cnt != 8) begin
      n_bad++;
      $display("FAIL ignore_rd_count: got %0d want 8", en_cnt);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL ignore_done_count: got %0d want 1", done_cnt);
    end
    n_cmp++;
    if (late_busy != 0) begin
      n_bad++;
      $display("FAIL ignore_requeue: busy cycles after done got %0d want 0", late_busy);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int set_cnt = 0;
    int en_cnt = 0;
    int set_cyc = -1;
    kick(0, 15'h0010);
    repeat (3) tick();
    n_cmp++;
    if (addr[0] !== 15'h0013 || en[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pre_row3: addr got %h en %b want 0013 1", addr[0], en[0]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (obs(0) !== 20'h0 || lanes(0) !== 64'h0) begin
      n_bad++;
      $display("FAIL abort_outputs: got %h lanes %h want 0", obs(0), lanes(0));
    end
    for (int c = 0; c < 12; c++) begin
      if (setw[0] === 1'b1) set_cnt++;
      tick();
    end
    n_cmp++;
    if (set_cnt != 0) begin
      n_bad++;
      $display("FAIL abort_no_set: got %0d set pulses want 0", set_cnt);
    end
    set_cnt = 0;
    kick(0, 15'h0010);
    for (int c = 1; c <= 12; c++) begin
      if (en[0] === 1'b1) en_cnt++;
      if (setw[0] === 1'b1) begin
        set_cnt++;
        set_cyc = c;
      end
      tick();
    end
    n_cmp++;
    if (set_cnt != 1 || set_cyc != 10 || en_cnt != 8) begin
      n_bad++;
      $display("FAIL abort_reload: sets %0d at %0d reads %0d want 1 at 10 reads 8",
               set_cnt, set_cyc, en_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    logic [14:0] exp_a [4];
    logic [14:0] got_a [4];
    int en_cnt = 0;
    int done_cyc = -1;
    exp_a = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    kick(1, 15'h7FFE);
    for (int c = 1; c <= 8; c++) begin
      if (en[1] === 1'b1) begin
        if (en_cnt < 4) got_a[en_cnt] = addr[1];
        en_cnt++;
      end
      if (done[1] === 1'b1) done_cyc = c;
      tick();
    end
    n_cmp++;
    if (en_cnt != 4) begin
      n_bad++;
      $display("FAIL wrap_rd_count: got %0d want 4", en_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (en_cnt > k && got_a[k] !== exp_a[k]) begin
        n_bad++;
        $display("FAIL wrap_addr%0d: got %h want %h", k, got_a[k], exp_a[k]);
      end else if (en_cnt <= k) begin
        n_bad++;
        $display("FAIL wrap_addr%0d: no read seen want %h", k, exp_a[k]);
      end
    end
    n_cmp++;
    if (done_cyc != 6) begin
      n_bad++;
      $display("FAIL wrap_latency: done at cycle %0d want 6", done_cyc);
    end
  endtask

  task automatic test_single_row();
    logic [19:0] exp_tbl [4];
    exp_tbl[0] = {1'b1, 15'h0123, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_tbl[1] = {1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_tbl[2] = {1'b0, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_tbl[3] = {1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    kick(2, 15'h0123);
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (obs(2) !== exp_tbl[c]) begin
        n_bad++;
        $display("FAIL rows1 cycle%0d: got %h want %h", c + 1, obs(2), exp_tbl[c]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_lane_map();
    test_busy_hold();
    test_start_ignored();
    test_reset_mid_fetch();
    test_addr_wrap();
    test_single_row();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_weight_loader.md
MAC_WEIGHT_LOADER -- requirements
Module: mac_weight_loader

Interface
REQ-001 SHALL have parameter ARRAY_ROWS, default 8: number of quad rows in the weight load chain; legal range 1..256.
REQ-002 SHALL have parameter BUFFER_ADDR_WIDTH, default 15: weight buffer address width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset; synchronous, active-low.
REQ-005 SHALL have port start_i, input, 1: load request, sampled only in IDLE.
REQ-006 SHALL have port base_addr_i, input, BUFFER_ADDR_WIDTH: first buffer word of the weight tile, sampled with start_i.
REQ-007 SHALL have port array_busy_i, input, 1: array is computing; set_weight is blocked while high.
REQ-008 SHALL have port buf_rd_en_o, output, 1: weight buffer read strobe.
REQ-009 SHALL have port buf_rd_addr_o, output, BUFFER_ADDR_WIDTH: weight buffer read address.
REQ-010 SHALL have port buf_rd_data_i, input, 64: buffer read data, valid exactly 1 cycle after buf_rd_en_o.
REQ-011 SHALL have port prepare_weight_o, output, 1: load chain shift enable.
REQ-012 SHALL have port set_weight_o, output, 1: one-cycle commit of shadow weights.
REQ-013 SHALL have ports o_load_weight_data_{a,b,c,d}_{0,1}, output, 8 each: load chain data for lanes a..d, slots 0/1.
REQ-014 SHALL have ports busy_o and done_o, output, 1 each: busy is level; done is a one-cycle pulse.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, DRAIN and SET.
REQ-016 In IDLE with start_i=1, SHALL latch base_addr_i, clear the row counter and enter FETCH.
REQ-017 In FETCH, SHALL assert buf_rd_en_o for exactly ARRAY_ROWS consecutive cycles, with buf_rd_addr_o = base+k for k = 0..ARRAY_ROWS-1, then enter DRAIN.
REQ-018 Address arithmetic SHALL wrap modulo 2^BUFFER_ADDR_WIDTH (base 0x7FFF, k=1 gives address 0x0000).
REQ-019 prepare_weight_o SHALL equal buf_rd_en_o delayed by one cycle: high for ARRAY_ROWS consecutive cycles, the last of which is the single DRAIN cycle.
REQ-020 While prepare_weight_o=1, the load data outputs SHALL map buf_rd_data_i as follows: [7:0]=a_0, [15:8]=b_0, [23:16]=c_0, [31:24]=d_0, [39:32]=a_1, [47:40]=b_1, [55:48]=c_1, [63:56]=d_1.
REQ-021 While prepare_weight_o=0, all load data outputs SHALL be 0.
REQ-022 The first word read SHALL be the weight for the row farthest from the loader.
REQ-023 In SET with array_busy_i=0, SHALL assert set_weight_o and done_o for one cycle, then return to IDLE.
REQ-024 In SET with array_busy_i=1, SHALL hold in SET with set_weight_o=0 for as many cycles as needed.
REQ-025 busy_o SHALL be 1 in FETCH, DRAIN and SET, and 0 in IDLE.
REQ-026 start_i outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-027 start_i in the same cycle as the done_o pulse SHALL be ignored; a new load requires start_i in IDLE.
REQ-028 With ARRAY_ROWS=1, FETCH SHALL last 1 cycle and DRAIN 1 cycle.
REQ-029 Minimum start-to-done latency SHALL be ARRAY_ROWS+2 cycles after the start-sampling edge.

Reset
REQ-030 While rst_n=0 at a clock edge, state SHALL become IDLE, the row counter 0 and the latched base 0.
REQ-031 While rst_n=0 at a clock edge, buf_rd_en_o, buf_rd_addr_o, prepare_weight_o, set_weight_o, busy_o, done_o and all load data outputs SHALL be 0.
REQ-032 A reset mid-FETCH or mid-SET SHALL abort with no set_weight_o pulse.
REQ-033 The first start_i SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-034 A shared package SHALL hold the FSM state typedef, the lane count (4), the slot count (2) and the byte-lane offset constants.
REQ-035 The block SHALL be a single module with no sub-module; the row counter and FSM SHALL be inline.

Verification
REQ-036 ARRAY_ROWS=8, base=0x0010, word k = 0x0101010101010101*(k+1) -> reads 0x0010..0x0017; prepare_weight_o high 8 cycles; a_0 sequence 01..08; set_weight_o and done_o pulse at cycle 10.
REQ-037 base=0x7FFE, ARRAY_ROWS=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
REQ-038 array_busy_i high for 5 cycles on entering SET -> set_weight_o delayed exactly 5 cycles; busy_o stays 1 throughout.
REQ-039 start_i pulsed during FETCH and on the done_o cycle -> no second load; buf_rd_en_o count is exactly ARRAY_ROWS.
REQ-040 rst_n low for 1 cycle at FETCH row 3 -> all outputs 0 next cycle; no set_weight_o; a new start_i then completes normally.
REQ-041 Word with only bits [63:56]=0xA5 -> o_load_weight_data_d_1=0xA5 and all other lanes 0.
